// File: rtl/tm1637_byte_tx_pkg.sv
// Shared definitions for the TM1637 byte transmitter: FSM state encodings
// and display command constants used by the upstream step sequencer.
package tm1637_byte_tx_pkg;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_BIT_LO = 4'd2;
    localparam logic [3:0] S_BIT_HI = 4'd3;
    localparam logic [3:0] S_ACK_LO = 4'd4;
    localparam logic [3:0] S_ACK_HI = 4'd5;
    localparam logic [3:0] S_HOLD   = 4'd6;
    localparam logic [3:0] S_STOP_A = 4'd7;
    localparam logic [3:0] S_STOP_B = 4'd8;
    localparam logic [3:0] S_STOP_C = 4'd9;

    typedef enum logic [3:0] {
        IDLE   = S_IDLE,
        START  = S_START,
        BIT_LO = S_BIT_LO,
        BIT_HI = S_BIT_HI,
        ACK_LO = S_ACK_LO,
        ACK_HI = S_ACK_HI,
        HOLD   = S_HOLD,
        STOP_A = S_STOP_A,
        STOP_B = S_STOP_B,
        STOP_C = S_STOP_C
    } state_t;

    localparam logic [7:0] CMD_DATA_AUTOINC = 8'h40;
    localparam logic [7:0] CMD_ADDR_BASE    = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON_BASE = 8'h88;

    function automatic logic [7:0] cmd_disp_on(input logic [2:0] bright);
        return CMD_DISP_ON_BASE | {5'd0, bright};
    endfunction

endpackage

// File: rtl/tm1637_byte_tx_half_tick.sv
// Half-step timer: reloads to HALF_PERIOD-1 on restart, counts down, holds at 0.
// Ports: clk, rst (sync, active high), restart (reload), tick (count is 0).
module tm1637_byte_tx_half_tick #(
    parameter int HALF_PERIOD = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(HALF_PERIOD);
    localparam logic [W-1:0] RELOAD = W'(HALF_PERIOD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/tm1637_byte_tx.sv
// TM1637 bit-level transmitter: START, 8 data bits LSB first, ACK clock, STOP.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data/in_start/in_stop
//  byte handshake; done (1-cycle pulse), ack_err (valid with done), busy;
//  tm1637_clk (push-pull), tm1637_dio_oe (1 = pull DIO low), tm1637_dio_i.
// Build option: define TM1637_ACK_CHECK_EN to report slave NACK on ack_err.
module tm1637_byte_tx
    import tm1637_byte_tx_pkg::*;
#(
    parameter int HALF_PERIOD = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_start,
    input  logic       in_stop,
    output logic       done,
    output logic       ack_err,
    output logic       busy,
    output logic       tm1637_clk,
    output logic       tm1637_dio_oe,
    input  logic       tm1637_dio_i
);

    state_t     state, state_d;
    logic [7:0] shift;
    logic [2:0] bitcnt;
    logic       stop_q;
    logic       restart_q;
    logic       done_d;
    logic       tick;
    logic       accept;

    assign accept = in_valid & in_ready;
    assign busy   = (state != IDLE);

    // Every state change reloads the timer so each state lasts HALF_PERIOD.
    tm1637_byte_tx_half_tick #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(state_d != state),
        .tick   (tick)
    );

    always_comb begin
        state_d       = state;
        in_ready      = 1'b0;
        tm1637_clk    = 1'b1;
        tm1637_dio_oe = 1'b0;
        done_d        = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_d = in_start ? START : BIT_LO;
            end
            START: begin
                tm1637_dio_oe = 1'b1;
                if (tick) state_d = BIT_LO;
            end
            BIT_LO: begin
                tm1637_clk    = 1'b0;
                tm1637_dio_oe = ~shift[0];
                if (tick) state_d = BIT_HI;
            end
            BIT_HI: begin
                tm1637_dio_oe = ~shift[0];
                if (tick) state_d = (bitcnt == 3'd7) ? ACK_LO : BIT_LO;
            end
            ACK_LO: begin
                tm1637_clk = 1'b0;
                if (tick) state_d = ACK_HI;
            end
            ACK_HI: begin
                if (tick) begin
                    if (stop_q) begin
                        state_d = STOP_A;
                    end else begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                tm1637_clk    = 1'b0;
                tm1637_dio_oe = 1'b1;
                in_ready      = 1'b1;
                // A framed burst is closed before a new START is issued.
                if (accept) state_d = in_start ? STOP_A : BIT_LO;
            end
            STOP_A: begin
                tm1637_clk    = 1'b0;
                tm1637_dio_oe = 1'b1;
                if (tick) state_d = STOP_B;
            end
            STOP_B: begin
                tm1637_dio_oe = 1'b1;
                if (tick) state_d = STOP_C;
            end
            STOP_C: begin
                if (tick) begin
                    if (restart_q) begin
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            bitcnt    <= '0;
            stop_q    <= 1'b0;
            restart_q <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            state <= state_d;
            done  <= done_d;
            if (accept) begin
                shift     <= in_data;
                bitcnt    <= '0;
                stop_q    <= in_stop;
                restart_q <= in_start && (state == HOLD);
                ack_err   <= 1'b0;
            end else if (state == BIT_HI && tick) begin
                shift  <= shift >> 1;
                bitcnt <= bitcnt + 3'd1;
            end
            // The STOP that precedes a re-START carries no done of its own.
            if (state == STOP_C && tick) restart_q <= 1'b0;
`ifdef TM1637_ACK_CHECK_EN
            if (state == ACK_HI && tick) ack_err <= tm1637_dio_i;
`endif
        end
    end

`ifndef TM1637_ACK_CHECK_EN
    logic unused_dio_i;
    assign unused_dio_i = tm1637_dio_i;
`endif

endmodule

// File: tb/tb_tm1637_byte_tx.sv
// Scoreboard bench for tm1637_byte_tx: bus decoder + ACK slave model,
// expected bus events and done timing pushed at accept time.
module tb_tm1637_byte_tx;

    localparam int HP       = 4;
    localparam int EV_START = 1000;
    localparam int EV_STOP  = 1001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_start = 1'b0;
    logic       in_stop = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready, done, ack_err, busy;
    logic       tm1637_clk, tm1637_dio_oe;
    logic       pull = 1'b0;
    wire        dio_line = ~(tm1637_dio_oe | pull);

    tm1637_byte_tx #(.HALF_PERIOD(HP)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_start     (in_start),
        .in_stop      (in_stop),
        .done         (done),
        .ack_err      (ack_err),
        .busy         (busy),
        .tm1637_clk   (tm1637_clk),
        .tm1637_dio_oe(tm1637_dio_oe),
        .tm1637_dio_i (dio_line)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit ack;
        bit hold;
    } done_t;

    done_t exp_done[$];
    int    exp_ev[$];
    bit    nackq[$];
    bit    bus_open = 1'b0;
    int    total = 0;
    int    bad = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic got_ev(input int v);
        if (exp_ev.size() == 0) check("unexpected_bus_event", v, -1);
        else check("bus_event", v, exp_ev.pop_front());
    endtask

    // Reference: a byte costs 16 bit half-steps + 2 ACK, plus 1 for START,
    // 3 for STOP, and a further 3 when a START must first close the burst.
    task automatic send(input logic [7:0] d, input bit s, input bit p,
                        input bit nack);
        int    n;
        int    budget;
        done_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_start = s;
        in_stop  = p;
        budget   = 0;
        while (!in_ready && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        n = 18;
        if (s && bus_open) begin
            exp_ev.push_back(EV_STOP);
            n += 3;
        end
        if (s) begin
            exp_ev.push_back(EV_START);
            n += 1;
        end
        exp_ev.push_back(int'(d) + (nack ? 256 : 0));
        if (p) begin
            exp_ev.push_back(EV_STOP);
            n += 3;
        end
        bus_open = !p;
        nackq.push_back(nack);
        e.cyc  = cyc + 1 + n * HP;
`ifdef TM1637_ACK_CHECK_EN
        e.ack  = nack;
`else
        e.ack  = 1'b0;
`endif
        e.hold = !p;
        exp_done.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((exp_done.size() != 0 || exp_ev.size() != 0) && b < 5000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 5000) check("drain_timeout", 0, 1);
    endtask

    // Bus decoder and slave: bits sampled on CLK rise, START/STOP as DIO
    // edges with CLK high; the slave pulls DIO low for the 9th clock.
    int         nb = 0;
    logic [7:0] abyte = 8'd0;
    bit         pc = 1'b1;
    bit         pd = 1'b1;

    always @(negedge clk) begin
        bit    c;
        bit    d;
        done_t e;
        c = tm1637_clk;
        d = dio_line;
        if (rst) begin
            nb   = 0;
            pull = 1'b0;
        end else begin
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_done.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("ack_err", int'(ack_err), int'(e.ack));
                    check("done_clk", int'(tm1637_clk), e.hold ? 0 : 1);
                    check("done_oe", int'(tm1637_dio_oe), e.hold ? 1 : 0);
                end
            end
            if (c && pc && d != pd) begin
                got_ev(d ? EV_STOP : EV_START);
                nb = 0;
            end else if (c && !pc) begin
                if (nb < 8) abyte[nb[2:0]] = d;
                else if (nb == 8) got_ev(int'(abyte) + (d ? 256 : 0));
                if (nb < 9) nb++;
            end else if (!c && pc) begin
                if (nb == 8) begin
                    pull = (nackq.size() != 0) ? !nackq.pop_front() : 1'b1;
                end else if (nb == 9) begin
                    pull = 1'b0;
                    nb   = 0;
                end
            end
        end
        pc = c;
        pd = d;
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk", int'(tm1637_clk), 1);
        check("rst_oe", int'(tm1637_dio_oe), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        send(8'h40, 1'b1, 1'b1, 1'b0);
        wait_drain();

        send(8'hC0, 1'b1, 1'b0, 1'b0);
        send(8'h3F, 1'b0, 1'b0, 1'b0);
        send(8'h06, 1'b0, 1'b1, 1'b0);
        wait_drain();

        send(8'h8F, 1'b1, 1'b1, 1'b1);
        wait_drain();

        send(8'h40, 1'b1, 1'b0, 1'b0);
        wait_drain();
        @(negedge clk);
        check("hold_clk", int'(tm1637_clk), 0);
        check("hold_ready", int'(in_ready), 1);
        send(8'h44, 1'b1, 1'b1, 1'b0);
        wait_drain();

        send(8'h40, 1'b1, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_clk", int'(tm1637_clk), 1);
        check("mid_rst_oe", int'(tm1637_dio_oe), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_busy", int'(busy), 0);
        exp_ev.delete();
        exp_done.delete();
        nackq.delete();
        bus_open = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(8'h40, 1'b1, 1'b1, 1'b0);
        wait_drain();

        for (int i = 0; i < 24; i++) begin
            send(8'($urandom), 1'($urandom), (i == 23) ? 1'b1 : 1'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        wait_drain();
        repeat (4) @(negedge clk);
        check("done_queue_empty", exp_done.size(), 0);
        check("event_queue_empty", exp_ev.size(), 0);
        check("final_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
